// File: rtl/column_loader.sv
// -----------------------------------------------------------------------------
// column_loader
//
// Purpose:
//    Double-buffered column store for a row-PWM display. Intensity samples
//    stream into a shadow register one slot per transfer; once every slot of
//    a column has been written the loader stops accepting data and waits for
//    the PWM period boundary (frame_sync), at which point the whole shadow
//    column is copied to the active register in a single edge. A frame_sync
//    that arrives before the column is complete leaves the active column
//    untouched and raises a sticky underrun flag.
//
// Ports:
//    clk         in   single clock, rising edge
//    rst         in   synchronous active-high reset
//    in_valid    in   upstream sample valid
//    in_data     in   intensity sample (0 = off, 2^IW-1 = brightest)
//    in_sof      in   sample is slot 0 of a new column (resync)
//    in_ready    out  loader accepts a sample this cycle
//    frame_sync  in   one-cycle pulse at the PWM period boundary
//    values      out  active column, slot i at [IW*i +: IW]
//    swapped     out  one-cycle pulse: values updated this cycle
//    underrun    out  sticky: frame_sync seen with the column incomplete
// -----------------------------------------------------------------------------
module column_loader #(
   parameter int N_ROWS = 32,
   parameter int IW     = 5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   input  logic [IW-1:0]          in_data,
   input  logic                   in_sof,
   output logic                   in_ready,
   input  logic                   frame_sync,
   output logic [N_ROWS*IW-1:0]   values,
   output logic                   swapped,
   output logic                   underrun
);

   localparam int IDXW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N_ROWS - 1);

   typedef enum logic {
      ST_LOAD = 1'b0,
      ST_FULL = 1'b1
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [IDXW-1:0]        r_idx;
   logic [IDXW-1:0]        w_idx_nxt;
   logic [IDXW-1:0]        w_slot;
   logic                   w_xfer;
   logic                   w_wr_en;
   logic                   w_swap;

   logic [N_ROWS*IW-1:0]   r_shadow;
   logic [N_ROWS*IW-1:0]   r_values;
   logic                   r_swapped;
   logic                   r_underrun;

   assign in_ready = (r_state == ST_LOAD);
   assign w_xfer   = in_valid & in_ready;

   // Next-state / write-control decode.
   always_comb begin
      // NOTE: every signal driven here gets a default first so no path leaves
      // it unassigned; otherwise synthesis infers a latch to hold old values.
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_slot      = r_idx;
      w_wr_en     = 1'b0;
      w_swap      = 1'b0;

      case (r_state)
         ST_LOAD: begin
            if (w_xfer) begin
               w_wr_en = 1'b1;
               if (in_sof) begin
                  // Resync: slot 0 regardless of where the index was.
                  w_slot    = '0;
                  w_idx_nxt = IDXW'(1);
               end else if (r_idx == LAST_IDX) begin
                  // Last slot written; a coincident frame_sync is still an
                  // underrun because the column was not complete before it.
                  w_idx_nxt   = '0;
                  w_state_nxt = ST_FULL;
               end else begin
                  w_idx_nxt = r_idx + IDXW'(1);
               end
            end
         end
         ST_FULL: begin
            if (frame_sync) begin
               w_swap      = 1'b1;
               w_idx_nxt   = '0;
               w_state_nxt = ST_LOAD;
            end
         end
         default: begin
            w_state_nxt = ST_LOAD;
            w_idx_nxt   = '0;
         end
      endcase
   end

   // State and write index.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      if (rst) begin
         r_state <= ST_LOAD;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   // Shadow / active column storage and status flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the column storage is cleared on reset on purpose: a reset
         // must blank the display and discard any partial column, so this is
         // not a plain data memory that could be left uninitialised.
         r_shadow   <= '0;
         r_values   <= '0;
         r_swapped  <= 1'b0;
         r_underrun <= 1'b0;
      end else begin
         if (w_wr_en) begin
            r_shadow[int'(w_slot)*IW +: IW] <= in_data;
         end
         // Whole-column copy in one edge: values is never partially updated.
         if (w_swap) begin
            r_values <= r_shadow;
         end
         r_swapped <= w_swap;
         if (frame_sync && (r_state == ST_LOAD)) begin
            r_underrun <= 1'b1;
         end
      end
   end

   assign values   = r_values;
   assign swapped  = r_swapped;
   assign underrun = r_underrun;

endmodule

// File: tb/tb_column_loader.sv
// -----------------------------------------------------------------------------
// tb_column_loader
//
// Purpose:
//    Directed, self-checking bench for column_loader with default parameters
//    (32 rows x 5 bits). A table of single-cycle vectors covers a full
//    load-and-swap; hand-written sequences cover underrun, resync, a
//    frame_sync coincident with the final sample, back-pressure in FULL and
//    reset in the middle of a column.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_column_loader;

   localparam int N_ROWS = 32;
   localparam int IW     = 5;
   localparam int VW     = N_ROWS * IW;

   logic            clk;
   logic            rst;
   logic            in_valid;
   logic [IW-1:0]   in_data;
   logic            in_sof;
   logic            in_ready;
   logic            frame_sync;
   logic [VW-1:0]   values;
   logic            swapped;
   logic            underrun;

   int n_checks = 0;
   int n_errors = 0;

   column_loader #(.N_ROWS(N_ROWS), .IW(IW)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_sof     (in_sof),
      .in_ready   (in_ready),
      .frame_sync (frame_sync),
      .values     (values),
      .swapped    (swapped),
      .underrun   (underrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic          valid;
      logic [IW-1:0] data;
      logic          sof;
      logic          fs;
      logic          exp_ready;
      logic          exp_swapped;
      logic          exp_underrun;
   } vec_t;

   vec_t tbl[34];

   task automatic check(input string name, input logic [VW-1:0] act,
                        input logic [VW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Inputs change 1 time unit after a rising edge; outputs are sampled at
   // the same point, i.e. they reflect the edge just taken.
   task automatic drive(input logic v, input logic [IW-1:0] d,
                        input logic sof, input logic fs);
      in_valid   = v;
      in_data    = d;
      in_sof     = sof;
      frame_sync = fs;
      @(posedge clk);
      #1;
      in_valid   = 1'b0;
      in_data    = '0;
      in_sof     = 1'b0;
      frame_sync = 1'b0;
   endtask

   // Reset with every other input active to show reset has priority.
   task automatic do_reset();
      rst        = 1'b1;
      in_valid   = 1'b1;
      in_data    = 5'd17;
      in_sof     = 1'b1;
      frame_sync = 1'b1;
      @(posedge clk);
      #1;
      rst        = 1'b0;
      in_valid   = 1'b0;
      in_data    = '0;
      in_sof     = 1'b0;
      frame_sync = 1'b0;
   endtask

   function automatic logic [VW-1:0] all_slots(input logic [IW-1:0] v);
      logic [VW-1:0] r;
      for (int i = 0; i < N_ROWS; i++) r[i*IW +: IW] = v;
      return r;
   endfunction

   logic [VW-1:0] exp_v;

   initial begin
      rst        = 1'b0;
      in_valid   = 1'b0;
      in_data    = '0;
      in_sof     = 1'b0;
      frame_sync = 1'b0;

      // Vector table: ramp load slot i = i, then swap, then idle.
      for (int i = 0; i < N_ROWS; i++) begin
         tbl[i] = '{valid: 1'b1, data: IW'(i), sof: (i == 0), fs: 1'b0,
                    exp_ready: (i != N_ROWS - 1), exp_swapped: 1'b0,
                    exp_underrun: 1'b0};
      end
      tbl[32] = '{valid: 1'b0, data: '0, sof: 1'b0, fs: 1'b1,
                  exp_ready: 1'b1, exp_swapped: 1'b1, exp_underrun: 1'b0};
      tbl[33] = '{valid: 1'b0, data: '0, sof: 1'b0, fs: 1'b0,
                  exp_ready: 1'b1, exp_swapped: 1'b0, exp_underrun: 1'b0};

      // ---- Reset state ----
      do_reset();
      check("rst_ready",    VW'(in_ready), VW'(1));
      check("rst_values",   values, '0);
      check("rst_swapped",  VW'(swapped), VW'(0));
      check("rst_underrun", VW'(underrun), VW'(0));

      // ---- Full ramp load + swap (table-driven) ----
      for (int k = 0; k < 34; k++) begin
         drive(tbl[k].valid, tbl[k].data, tbl[k].sof, tbl[k].fs);
         check($sformatf("tbl%0d_ready", k),    VW'(in_ready), VW'(tbl[k].exp_ready));
         check($sformatf("tbl%0d_swapped", k),  VW'(swapped),  VW'(tbl[k].exp_swapped));
         check($sformatf("tbl%0d_underrun", k), VW'(underrun), VW'(tbl[k].exp_underrun));
         if (k < 32) check($sformatf("tbl%0d_values", k), values, '0);
      end
      for (int i = 0; i < N_ROWS; i++) exp_v[i*IW +: IW] = IW'(i);
      check("ramp_values", values, exp_v);

      // ---- Early frame_sync: underrun, loading continues ----
      do_reset();
      for (int i = 0; i < 10; i++) drive(1'b1, IW'(i + 1), (i == 0), 1'b0);
      drive(1'b0, '0, 1'b0, 1'b1);
      check("early_values",   values, '0);
      check("early_underrun", VW'(underrun), VW'(1));
      check("early_swapped",  VW'(swapped), VW'(0));
      check("early_ready",    VW'(in_ready), VW'(1));
      for (int i = 10; i < N_ROWS; i++) drive(1'b1, IW'(i + 1), 1'b0, 1'b0);
      check("early_full_ready", VW'(in_ready), VW'(0));
      drive(1'b0, '0, 1'b0, 1'b1);
      for (int i = 0; i < N_ROWS; i++) exp_v[i*IW +: IW] = IW'(i + 1);
      check("early_swap_values",   values, exp_v);
      check("early_swap_pulse",    VW'(swapped), VW'(1));
      check("early_underrun_hold", VW'(underrun), VW'(1));

      // ---- in_sof resync mid-column ----
      do_reset();
      for (int i = 0; i < 6; i++) drive(1'b1, 5'd7, (i == 0), 1'b0);
      drive(1'b1, 5'd31, 1'b1, 1'b0);
      for (int i = 1; i < N_ROWS; i++) drive(1'b1, 5'd3, 1'b0, 1'b0);
      check("resync_full_ready", VW'(in_ready), VW'(0));
      drive(1'b0, '0, 1'b0, 1'b1);
      exp_v = all_slots(5'd3);
      exp_v[IW-1:0] = 5'd31;
      check("resync_values",   values, exp_v);
      check("resync_underrun", VW'(underrun), VW'(0));

      // ---- frame_sync with final sample, then back-pressure in FULL ----
      do_reset();
      for (int i = 0; i < N_ROWS - 1; i++) drive(1'b1, 5'd2, (i == 0), 1'b0);
      drive(1'b1, 5'd2, 1'b0, 1'b1);
      check("coinc_ready",    VW'(in_ready), VW'(0));
      check("coinc_swapped",  VW'(swapped), VW'(0));
      check("coinc_underrun", VW'(underrun), VW'(1));
      check("coinc_values",   values, '0);
      for (int c = 0; c < 20; c++) begin
         drive(1'b1, 5'd9, (c == 5), 1'b0);
         check($sformatf("full_hold%0d_ready", c), VW'(in_ready), VW'(0));
      end
      check("full_hold_values", values, '0);
      drive(1'b0, '0, 1'b0, 1'b1);
      check("full_swap_values",  values, all_slots(5'd2));
      check("full_swap_pulse",   VW'(swapped), VW'(1));
      check("full_swap_ready",   VW'(in_ready), VW'(1));
      drive(1'b0, '0, 1'b0, 1'b0);
      check("full_swap_pulse_end", VW'(swapped), VW'(0));
      check("full_swap_values_hold", values, all_slots(5'd2));

      // ---- Reset mid-load after a bright column ----
      do_reset();
      for (int i = 0; i < N_ROWS; i++) drive(1'b1, 5'h1F, (i == 0), 1'b0);
      drive(1'b0, '0, 1'b0, 1'b1);
      check("bright_values", values, all_slots(5'h1F));
      for (int i = 0; i < 5; i++) drive(1'b1, 5'd6, (i == 0), 1'b0);
      drive(1'b0, '0, 1'b0, 1'b1);
      check("bright_underrun", VW'(underrun), VW'(1));
      do_reset();
      check("midrst_values",   values, '0);
      check("midrst_underrun", VW'(underrun), VW'(0));
      check("midrst_ready",    VW'(in_ready), VW'(1));
      // idx must be 0: exactly 32 samples without in_sof fill the column.
      for (int i = 0; i < N_ROWS - 1; i++) drive(1'b1, 5'd4, 1'b0, 1'b0);
      check("midrst_idx_not_full", VW'(in_ready), VW'(1));
      drive(1'b1, 5'd4, 1'b0, 1'b0);
      check("midrst_idx_full", VW'(in_ready), VW'(0));
      drive(1'b0, '0, 1'b0, 1'b1);
      check("midrst_swap_values", values, all_slots(5'd4));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
